apb_norflash_bridge: RTL and testbench
======================================

// Module: apb_norflash_bridge
// PURPOSE
//  APB3 slave that sits directly upstream of the NOR flash controller and drives its command interface.
//  Software programs ADDR/WDATA/CTRL, and the block launches one command (read, byte program, sector erase).
//  It holds cmd/addr/data stable, raises a req level (rising edge = launch) until the controller's 1-cycle ack,
//  latches read data, and reports completion, errors and timeout through STATUS and irq_o.
// PARAMETERS
//  ASIZE    22          flash address width
//  DSIZE    8           flash data width
//  TMO_RST  50_000_000  reset value of TIMEOUT register, in sys_clk cycles (1 s @50 MHz, > 0.7 s sector erase)
// PORTS
//  sys_clk        in   1      system clock, all logic on posedge
//  sys_rst_n      in   1      asynchronous active-low reset
//  psel           in   1      APB select
//  penable        in   1      APB access phase
//  pwrite         in   1      APB direction, 1 = write
//  paddr          in   8      APB byte address; [7:2] decoded, [1:0] ignored
//  pwdata         in   32     APB write data
//  prdata         out  32     APB read data, valid in access phase
//  pready         out  1      tied 1, zero wait states
//  pslverr        out  1      error response for the current access phase
//  sys_cmd_o      out  3      command to controller: 0 = read, 1 = byte write, 2 = sector erase
//  flash_req_o    out  1      request level; controller launches on its rising edge
//  flash_ack_i    in   1      1-cycle completion pulse from controller
//  sys_rd_addr_o  out  ASIZE  read address (= ADDR)
//  sys_wr_addr_o  out  ASIZE  write/sector address (= ADDR)
//  sys_data_o     out  DSIZE  program data (= WDATA)
//  sys_data_i     in   DSIZE  read data from controller, valid when flash_ack_i is high
//  irq_o          out  1      level interrupt = IE & (DONE | TMO)
// BEHAVIOUR
//  Registers (offset: fields). Reset values in brackets.
//   0x00 CTRL   : [2:0] CMD [0], [8] IE [0], [16] START (write-1 self-clearing, reads 0)
//   0x04 ADDR   : [ASIZE-1:0] [0]
//   0x08 WDATA  : [DSIZE-1:0] [0]
//   0x0C RDATA  : [DSIZE-1:0] RO [0]
//   0x10 STATUS : [0] BUSY RO, [1] DONE W1C, [2] ERR W1C, [3] TMO W1C [all 0]
//   0x14 TIMEOUT: [31:0] [TMO_RST]
//  APB:
//   - A write or read takes effect in the access phase (psel & penable); pready = 1.
//   - pslverr = 1 for: unmapped offset; a write to CTRL/ADDR/WDATA/TIMEOUT while BUSY (write is dropped, ERR set).
//     An RDATA write is ignored without error.
//  Launch: a CTRL write with START = 1 while idle.
//   - If CMD > 2: no launch, ERR set, pslverr = 0.
//   - Otherwise: BUSY = 1 and DONE/TMO are cleared.
//  FSM states:
//   IDLE   : req = 0. Valid START -> REQ.
//   REQ    : req = 1 from the next cycle; timeout counter cleared -> WAIT.
//   WAIT   : req held at 1; counter += 1 each cycle.
//            flash_ack_i -> RDATA <= sys_data_i (CMD == 0 only), DONE = 1 -> GAP.
//            counter == TIMEOUT - 1 without ack -> TMO = 1 -> GAP.
//            If ack and timeout land in the same cycle, ack wins.
//   GAP    : req = 0 for exactly 1 cycle so the next launch produces a fresh rising edge -> IDLE, BUSY = 0.
//  Latency: flash_req_o rises 2 cycles after the START access phase. BUSY falls 2 cycles after flash_ack_i.
//  sys_cmd_o, the address outputs and sys_data_o are driven from CMD/ADDR/WDATA and are frozen while BUSY.
//  flash_ack_i outside WAIT is ignored.
//  W1C: a 1 written to a STATUS bit clears it. A set event in the same cycle wins over the clear.
//  TIMEOUT = 0 behaves as 1 (timeout fires after 1 cycle of WAIT).
//  Reset (asynchronous, any state, including mid-WAIT): FSM -> IDLE, flash_req_o = 0, prdata = 0, pslverr = 0,
//   irq_o = 0, sys_cmd_o = 0, all address/data outputs = 0, registers to their reset values.
// TESTING
//  1. ADDR = 0x123, CMD = 0, START; controller model acks after 4 cycles with 0x5A
//     -> one req rise, RDATA = 0x5A, DONE = 1, BUSY = 0, irq_o = IE.
//  2. ADDR = 0x3FFFFF, WDATA = 0xA5, CMD = 1, START
//     -> sys_wr_addr_o = 0x3FFFFF, sys_data_o = 0xA5 held stable until ack; RDATA unchanged.
//  3. While BUSY, write ADDR = 0x1 -> pslverr = 1, ERR = 1, sys_rd_addr_o unchanged; W1C ERR clears it.
//  4. TIMEOUT = 10, CMD = 2, START, no ack -> TMO = 1 exactly 10 cycles into WAIT, req drops, next START relaunches.
//  5. CMD = 5, START -> no req edge, ERR = 1; access to offset 0x18 -> pslverr = 1.
//  6. Back-to-back reads -> req is low at least 1 cycle between launches; sys_rst_n low mid-WAIT -> all outputs 0 at once.

Source files
------------

// File: rtl/apb_norflash_bridge.sv
// APB3 register front-end for the NOR flash controller: launches one read, byte-program
// or sector-erase command over a req/ack handshake and reports completion, error and timeout.
module apb_norflash_bridge #(
   parameter int unsigned ASIZE   = 22,
   parameter int unsigned DSIZE   = 8,
   parameter int unsigned TMO_RST = 50_000_000
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             psel,
   input  logic             penable,
   input  logic             pwrite,
   input  logic [7:0]       paddr,
   input  logic [31:0]      pwdata,
   output logic [31:0]      prdata,
   output logic             pready,
   output logic             pslverr,
   output logic [2:0]       sys_cmd_o,
   output logic             flash_req_o,
   input  logic             flash_ack_i,
   output logic [ASIZE-1:0] sys_rd_addr_o,
   output logic [ASIZE-1:0] sys_wr_addr_o,
   output logic [DSIZE-1:0] sys_data_o,
   input  logic [DSIZE-1:0] sys_data_i,
   output logic             irq_o
);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_GAP} state_t;

   localparam logic [5:0] OFF_CTRL    = 6'd0;
   localparam logic [5:0] OFF_ADDR    = 6'd1;
   localparam logic [5:0] OFF_WDATA   = 6'd2;
   localparam logic [5:0] OFF_RDATA   = 6'd3;
   localparam logic [5:0] OFF_STATUS  = 6'd4;
   localparam logic [5:0] OFF_TIMEOUT = 6'd5;

   state_t            r_state;
   state_t            w_next_state;
   logic [2:0]        r_cmd;
   logic              r_ie;
   logic [ASIZE-1:0]  r_addr;
   logic [DSIZE-1:0]  r_wdata;
   logic [DSIZE-1:0]  r_rdata;
   logic              r_done;
   logic              r_err;
   logic              r_tmo;
   logic [31:0]       r_timeout;
   logic [31:0]       r_cnt;
   logic              r_req;

   logic [5:0]        w_off;
   logic              w_acc;
   logic              w_wr;
   logic              w_rd;
   logic              w_mapped;
   logic              w_busy;
   logic              w_cfg_off;
   logic              w_wr_blocked;
   logic              w_start;
   logic              w_bad_cmd;
   logic              w_launch;
   logic              w_cfg_wr;
   logic              w_st_wr;
   logic              w_ack;
   logic              w_tmo_hit;
   logic [31:0]       w_tmo_eff;
   logic [31:0]       w_rd_mux;
   logic              w_unused;

   assign w_unused = ^paddr[1:0];

   assign w_off        = paddr[7:2];
   assign w_acc        = psel & penable;
   assign w_wr         = w_acc & pwrite;
   assign w_rd         = w_acc & ~pwrite;
   assign w_mapped     = (w_off <= OFF_TIMEOUT);
   assign w_busy       = (r_state != ST_IDLE);
   assign w_cfg_off    = (w_off == OFF_CTRL) | (w_off == OFF_ADDR) |
                         (w_off == OFF_WDATA) | (w_off == OFF_TIMEOUT);
   assign w_wr_blocked = w_wr & w_busy & w_cfg_off;
   assign w_cfg_wr     = w_wr & ~w_busy;
   assign w_st_wr      = w_wr & (w_off == OFF_STATUS);
   assign w_start      = w_cfg_wr & (w_off == OFF_CTRL) & pwdata[16];
   assign w_bad_cmd    = w_start & (pwdata[2:0] > 3'd2);
   assign w_launch     = w_start & ~w_bad_cmd;

   // TIMEOUT of 0 is treated as 1 so the compare below never wraps
   assign w_tmo_eff = (r_timeout == '0) ? 32'd1 : r_timeout;
   assign w_ack     = (r_state == ST_WAIT) & flash_ack_i;
   assign w_tmo_hit = (r_state == ST_WAIT) & ~flash_ack_i & (r_cnt == (w_tmo_eff - 32'd1));

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: if (w_launch) w_next_state = ST_REQ;
         ST_REQ:  w_next_state = ST_WAIT;
         ST_WAIT: if (w_ack || w_tmo_hit) w_next_state = ST_GAP;
         ST_GAP:  w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   // req is high exactly for the WAIT cycles, giving a low GAP cycle before any relaunch
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_req <= 1'b0;
         r_cnt <= '0;
      end else begin
         r_req <= (w_next_state == ST_WAIT);
         if (r_state == ST_REQ) begin
            r_cnt <= '0;
         end else if (r_state == ST_WAIT) begin
            r_cnt <= r_cnt + 32'd1;
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_cmd     <= '0;
         r_ie      <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_timeout <= 32'(TMO_RST);
      end else if (w_cfg_wr) begin
         case (w_off)
            OFF_CTRL: begin
               r_cmd <= pwdata[2:0];
               r_ie  <= pwdata[8];
            end
            OFF_ADDR:    r_addr    <= pwdata[ASIZE-1:0];
            OFF_WDATA:   r_wdata   <= pwdata[DSIZE-1:0];
            OFF_TIMEOUT: r_timeout <= pwdata;
            default: ;
         endcase
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_rdata <= '0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_tmo   <= 1'b0;
      end else begin
         if (w_ack && (r_cmd == 3'd0)) begin
            r_rdata <= sys_data_i;
         end
         if (w_ack) begin
            r_done <= 1'b1;
         end else if (w_launch || (w_st_wr && pwdata[1])) begin
            r_done <= 1'b0;
         end
         if (w_wr_blocked || w_bad_cmd) begin
            r_err <= 1'b1;
         end else if (w_st_wr && pwdata[2]) begin
            r_err <= 1'b0;
         end
         if (w_tmo_hit) begin
            r_tmo <= 1'b1;
         end else if (w_launch || (w_st_wr && pwdata[3])) begin
            r_tmo <= 1'b0;
         end
      end
   end

   always_comb begin
      w_rd_mux = '0;
      case (w_off)
         OFF_CTRL: begin
            w_rd_mux[2:0] = r_cmd;
            w_rd_mux[8]   = r_ie;
         end
         OFF_ADDR:    w_rd_mux[ASIZE-1:0] = r_addr;
         OFF_WDATA:   w_rd_mux[DSIZE-1:0] = r_wdata;
         OFF_RDATA:   w_rd_mux[DSIZE-1:0] = r_rdata;
         OFF_STATUS:  w_rd_mux[3:0]       = {r_tmo, r_err, r_done, w_busy};
         OFF_TIMEOUT: w_rd_mux            = r_timeout;
         default: ;
      endcase
   end

   assign prdata        = w_rd ? w_rd_mux : '0;
   assign pready        = 1'b1;
   assign pslverr       = w_acc & (~w_mapped | w_wr_blocked);
   assign sys_cmd_o     = r_cmd;
   assign flash_req_o   = r_req;
   assign sys_rd_addr_o = r_addr;
   assign sys_wr_addr_o = r_addr;
   assign sys_data_o    = r_wdata;
   assign irq_o         = r_ie & (r_done | r_tmo);

endmodule

// File: tb/tb_apb_norflash_bridge.sv
// Bench for apb_norflash_bridge: APB master tasks, a flash controller model with a
// configurable ack delay, and a launch scoreboard checked on every req rising edge.
module tb_apb_norflash_bridge;

   localparam int unsigned ASIZE   = 22;
   localparam int unsigned DSIZE   = 8;
   localparam int unsigned TMO_RST = 50_000_000;

   localparam logic [7:0] A_CTRL = 8'h00, A_ADDR = 8'h04, A_WDATA = 8'h08;
   localparam logic [7:0] A_RDATA = 8'h0C, A_STATUS = 8'h10, A_TIMEOUT = 8'h14;

   typedef struct {
      logic [2:0]       cmd;
      logic [ASIZE-1:0] addr;
      logic [DSIZE-1:0] data;
   } launch_t;

   logic             sys_clk;
   logic             sys_rst_n;
   logic             psel, penable, pwrite;
   logic [7:0]       paddr;
   logic [31:0]      pwdata, prdata;
   logic             pready, pslverr;
   logic [2:0]       sys_cmd_o;
   logic             flash_req_o, flash_ack_i;
   logic [ASIZE-1:0] sys_rd_addr_o, sys_wr_addr_o;
   logic [DSIZE-1:0] sys_data_o, sys_data_i;
   logic             irq_o;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int unsigned req_rises = 0;
   int unsigned low_cnt = 100;
   bit          ack_en = 1'b1;
   int unsigned ack_dly = 4;
   logic [7:0]  ack_data = 8'h00;
   launch_t     sb[$];

   apb_norflash_bridge #(.ASIZE(ASIZE), .DSIZE(DSIZE), .TMO_RST(TMO_RST)) u_dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
      .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
      .sys_cmd_o(sys_cmd_o), .flash_req_o(flash_req_o), .flash_ack_i(flash_ack_i),
      .sys_rd_addr_o(sys_rd_addr_o), .sys_wr_addr_o(sys_wr_addr_o),
      .sys_data_o(sys_data_o), .sys_data_i(sys_data_i), .irq_o(irq_o)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic apb_xfer(input logic wr, input logic [7:0] a, input logic [31:0] d,
                           output logic [31:0] rd, output logic err);
      @(posedge sys_clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
      @(posedge sys_clk); #1;
      penable = 1'b1;
      @(negedge sys_clk);
      rd  = prdata;
      err = pslverr;
      chk("pready", {31'b0, pready}, 32'h1);
      @(posedge sys_clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic apb_wr(input logic [7:0] a, input logic [31:0] d, output logic err);
      logic [31:0] rd;
      apb_xfer(1'b1, a, d, rd, err);
   endtask

   task automatic apb_rd(input logic [7:0] a, output logic [31:0] rd, output logic err);
      apb_xfer(1'b0, a, 32'h0, rd, err);
   endtask

   task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
      logic [31:0] rd;
      logic        e;
      apb_rd(a, rd, e);
      chk(tag, rd, exp);
   endtask

   task automatic launch(input logic [2:0] cmd, input logic [ASIZE-1:0] addr,
                         input logic [DSIZE-1:0] data);
      launch_t l;
      logic    e;
      l.cmd = cmd; l.addr = addr; l.data = data;
      sb.push_back(l);
      apb_wr(A_CTRL, 32'h0001_0100 | {29'b0, cmd}, e);
      chk("start_slverr", {31'b0, e}, 32'h0);
   endtask

   task automatic wait_idle();
      logic [31:0] st;
      logic        e;
      st = 32'h1;
      for (int i = 0; i < 60; i++) begin
         apb_rd(A_STATUS, st, e);
         if (st[0] == 1'b0) break;
      end
      chk("idle_wait", {31'b0, st[0]}, 32'h0);
   endtask

   task automatic wait_req_high();
      for (int i = 0; i < 10; i++) begin
         @(posedge sys_clk); #1;
         if (flash_req_o) break;
      end
      chk("req_seen", {31'b0, flash_req_o}, 32'h1);
   endtask

   // Flash controller model plus launch scoreboard
   initial begin : ctrl_model
      logic        req_q;
      int unsigned cnt;
      bit          pend;
      launch_t     cur;
      req_q = 1'b0; pend = 1'b0; cnt = 0;
      cur.cmd = '0; cur.addr = '0; cur.data = '0;
      flash_ack_i = 1'b0;
      sys_data_i  = '0;
      forever begin
         @(posedge sys_clk); #1;
         flash_ack_i = 1'b0;
         if (!sys_rst_n) begin
            pend  = 1'b0;
            req_q = 1'b0;
         end else begin
            if (flash_req_o && !req_q) begin
               req_rises++;
               chk("req_gap", {31'b0, (low_cnt >= 1)}, 32'h1);
               chk("sb_nonempty", {31'b0, (sb.size() != 0)}, 32'h1);
               if (sb.size() != 0) begin
                  cur = sb.pop_front();
                  chk("cmd_launch", {29'b0, sys_cmd_o}, {29'b0, cur.cmd});
                  chk("rdaddr_launch", {10'b0, sys_rd_addr_o}, {10'b0, cur.addr});
                  chk("wraddr_launch", {10'b0, sys_wr_addr_o}, {10'b0, cur.addr});
                  chk("data_launch", {24'b0, sys_data_o}, {24'b0, cur.data});
               end
               if (ack_en) begin
                  pend = 1'b1;
                  cnt  = ack_dly;
               end
            end else if (flash_req_o) begin
               chk("cmd_hold", {29'b0, sys_cmd_o}, {29'b0, cur.cmd});
               chk("wraddr_hold", {10'b0, sys_wr_addr_o}, {10'b0, cur.addr});
               chk("data_hold", {24'b0, sys_data_o}, {24'b0, cur.data});
               if (pend) begin
                  if (cnt <= 1) begin
                     flash_ack_i = 1'b1;
                     sys_data_i  = ack_data;
                     pend        = 1'b0;
                  end else begin
                     cnt--;
                  end
               end
            end
            low_cnt = flash_req_o ? 0 : low_cnt + 1;
            req_q   = flash_req_o;
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [31:0] rd;
      logic        e;
      int unsigned rises0;

      sys_rst_n = 1'b0;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
      repeat (3) @(posedge sys_clk);
      #1;
      chk("rst_req", {31'b0, flash_req_o}, 32'h0);
      chk("rst_irq", {31'b0, irq_o}, 32'h0);
      chk("rst_cmd", {29'b0, sys_cmd_o}, 32'h0);
      sys_rst_n = 1'b1;
      rd_chk("rst_ctrl", A_CTRL, 32'h0);
      rd_chk("rst_status", A_STATUS, 32'h0);
      rd_chk("rst_timeout", A_TIMEOUT, TMO_RST);

      // 1: read at 0x123, ack after 4 cycles with 0x5A
      apb_wr(A_ADDR, 32'h123, e);
      ack_en = 1'b1; ack_dly = 4; ack_data = 8'h5A;
      rises0 = req_rises;
      launch(3'd0, 22'h123, 8'h00);
      chk("lat_req0", {31'b0, flash_req_o}, 32'h0);
      @(posedge sys_clk); #1;
      chk("lat_req1", {31'b0, flash_req_o}, 32'h1);
      wait_idle();
      chk("t1_rises", req_rises - rises0, 32'd1);
      rd_chk("t1_rdata", A_RDATA, 32'h5A);
      rd_chk("t1_status", A_STATUS, 32'h2);
      chk("t1_irq", {31'b0, irq_o}, 32'h1);

      // 2: byte program at top address; RDATA must not change
      apb_wr(A_ADDR, 32'h3F_FFFF, e);
      apb_wr(A_WDATA, 32'hA5, e);
      ack_dly = 6; ack_data = 8'hEE;
      launch(3'd1, 22'h3F_FFFF, 8'hA5);
      wait_idle();
      chk("t2_wraddr", {10'b0, sys_wr_addr_o}, 32'h3F_FFFF);
      chk("t2_data", {24'b0, sys_data_o}, 32'hA5);
      rd_chk("t2_rdata", A_RDATA, 32'h5A);

      // 3: config write while busy is rejected; ERR is W1C
      ack_dly = 30; ack_data = 8'hC3;
      launch(3'd0, 22'h3F_FFFF, 8'hA5);
      apb_wr(A_ADDR, 32'h1, e);
      chk("t3_slverr", {31'b0, e}, 32'h1);
      chk("t3_rdaddr", {10'b0, sys_rd_addr_o}, 32'h3F_FFFF);
      rd_chk("t3_status_err", A_STATUS, 32'h5);
      apb_wr(A_STATUS, 32'h4, e);
      chk("t3_w1c_slverr", {31'b0, e}, 32'h0);
      rd_chk("t3_status_clr", A_STATUS, 32'h1);
      wait_idle();
      rd_chk("t3_rdata", A_RDATA, 32'hC3);
      rd_chk("t3_addr", A_ADDR, 32'h3F_FFFF);

      // 4: erase with TIMEOUT = 10 and no ack
      apb_wr(A_TIMEOUT, 32'd10, e);
      ack_en = 1'b0;
      launch(3'd2, 22'h3F_FFFF, 8'hA5);
      wait_req_high();
      repeat (9) @(posedge sys_clk);
      #1;
      chk("t4_req_cyc10", {31'b0, flash_req_o}, 32'h1);
      chk("t4_irq_cyc10", {31'b0, irq_o}, 32'h0);
      @(posedge sys_clk); #1;
      chk("t4_req_drop", {31'b0, flash_req_o}, 32'h0);
      chk("t4_irq_tmo", {31'b0, irq_o}, 32'h1);
      rd_chk("t4_status", A_STATUS, 32'h8);
      ack_en = 1'b1; ack_dly = 3;
      rises0 = req_rises;
      launch(3'd2, 22'h3F_FFFF, 8'hA5);
      wait_idle();
      chk("t4_relaunch", req_rises - rises0, 32'd1);
      rd_chk("t4_status2", A_STATUS, 32'h2);

      // TIMEOUT = 0 fires after a single WAIT cycle
      apb_wr(A_TIMEOUT, 32'd0, e);
      ack_en = 1'b0;
      launch(3'd2, 22'h3F_FFFF, 8'hA5);
      wait_req_high();
      @(posedge sys_clk); #1;
      chk("t4_tmo0_drop", {31'b0, flash_req_o}, 32'h0);
      rd_chk("t4_tmo0_status", A_STATUS, 32'h8);

      // 5: illegal command, unmapped offset, RDATA write
      rises0 = req_rises;
      apb_wr(A_CTRL, 32'h0001_0105, e);
      chk("t5_badcmd_slverr", {31'b0, e}, 32'h0);
      repeat (5) @(posedge sys_clk);
      #1;
      chk("t5_no_rise", req_rises - rises0, 32'd0);
      rd_chk("t5_status", A_STATUS, 32'hC);
      apb_rd(8'h18, rd, e);
      chk("t5_unmapped_rd", {31'b0, e}, 32'h1);
      apb_wr(8'h18, 32'hFFFF_FFFF, e);
      chk("t5_unmapped_wr", {31'b0, e}, 32'h1);
      apb_wr(A_RDATA, 32'h99, e);
      chk("t5_rdata_wr_err", {31'b0, e}, 32'h0);
      rd_chk("t5_rdata", A_RDATA, 32'hC3);

      // 6: back-to-back reads, then reset mid-WAIT
      apb_wr(A_STATUS, 32'hE, e);
      apb_wr(A_TIMEOUT, 32'd100, e);
      apb_wr(A_ADDR, 32'h55, e);
      ack_en = 1'b1; ack_dly = 2; ack_data = 8'h11;
      rises0 = req_rises;
      launch(3'd0, 22'h55, 8'hA5);
      wait_idle();
      ack_data = 8'h22;
      launch(3'd0, 22'h55, 8'hA5);
      wait_idle();
      chk("t6_rises", req_rises - rises0, 32'd2);
      rd_chk("t6_rdata", A_RDATA, 32'h22);

      apb_wr(A_ADDR, 32'h2A_AAAA, e);
      apb_wr(A_WDATA, 32'h77, e);
      ack_en = 1'b0;
      launch(3'd2, 22'h2A_AAAA, 8'h77);
      wait_req_high();
      sys_rst_n = 1'b0;
      #1;
      chk("t6_rst_req", {31'b0, flash_req_o}, 32'h0);
      chk("t6_rst_cmd", {29'b0, sys_cmd_o}, 32'h0);
      chk("t6_rst_rdaddr", {10'b0, sys_rd_addr_o}, 32'h0);
      chk("t6_rst_wraddr", {10'b0, sys_wr_addr_o}, 32'h0);
      chk("t6_rst_data", {24'b0, sys_data_o}, 32'h0);
      chk("t6_rst_irq", {31'b0, irq_o}, 32'h0);
      chk("t6_rst_slverr", {31'b0, pslverr}, 32'h0);
      chk("t6_rst_prdata", prdata, 32'h0);
      @(posedge sys_clk); #1;
      sys_rst_n = 1'b1;
      rd_chk("t6_post_timeout", A_TIMEOUT, TMO_RST);
      rd_chk("t6_post_status", A_STATUS, 32'h0);
      rd_chk("t6_post_ctrl", A_CTRL, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
